// File: rtl/opb_register_bank.sv
// OPB slave exposing a small bank of 32-bit user registers.
// Registers may be plain read/write, self-clearing pulse, or read-only status.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for a select hit inside the address window
// S_ACK   | transfer latched; Sl_xferAck high, read data on Sl_DBus
// S_DESEL | transfer done; wait for OPB_select to drop before re-arming
module opb_register_bank #(
   parameter logic [31:0]           C_BASEADDR   = 32'h0000_0000,
   parameter logic [31:0]           C_HIGHADDR   = 32'h0000_00FF,
   parameter int                    C_OPB_AWIDTH = 32,
   parameter int                    C_OPB_DWIDTH = 32,
   parameter int                    C_NUM_REGS   = 4,
   parameter logic [C_NUM_REGS-1:0] C_PULSE_MASK = '0,
   parameter logic [C_NUM_REGS-1:0] C_RO_MASK    = '0,
   parameter string                 C_FAMILY     = "virtex5"
) (
   input  logic                       OPB_Clk,
   input  logic                       OPB_Rst,
   input  logic [0:31]                OPB_ABus,
   input  logic [0:3]                 OPB_BE,
   input  logic [0:31]                OPB_DBus,
   input  logic                       OPB_RNW,
   input  logic                       OPB_select,
   input  logic                       OPB_seqAddr,
   output logic [0:31]                Sl_DBus,
   output logic                       Sl_xferAck,
   output logic                       Sl_errAck,
   output logic                       Sl_retry,
   output logic                       Sl_toutSup,
   output logic [C_NUM_REGS*32-1:0]   user_data_out,
   output logic [C_NUM_REGS-1:0]      user_wr_strobe,
   input  logic [C_NUM_REGS*32-1:0]   user_data_in
);

   typedef enum logic [1:0] {S_IDLE, S_ACK, S_DESEL} state_t;

   localparam logic [31:0] SPAN = C_HIGHADDR - C_BASEADDR;

   state_t                state_q, state_d;
   logic [31:0]           regs_q [C_NUM_REGS];
   logic [31:0]           regs_d [C_NUM_REGS];
   logic [C_NUM_REGS-1:0] strobe_q, strobe_d;
   logic [29:0]           idx_q;
   logic                  rnw_q;
   logic [3:0]            be_q;
   logic [31:0]           wdata_q;
   logic [31:0]           rdata_q;

   logic [32:0]           diff_c;
   logic [29:0]           idx_c;
   logic                  hit_c;
   logic                  wr_en_c;
   logic [31:0]           rd_c;
   logic [31:0]           be_mask_c;
   logic [1:0]            unused_byte_off;
   logic                  unused_seqaddr;

   // 33-bit subtract: bit 32 flags an address below the base
   assign diff_c          = {1'b0, OPB_ABus} - {1'b0, C_BASEADDR};
   assign hit_c           = OPB_select && !diff_c[32] && (diff_c[31:0] <= SPAN);
   assign idx_c           = diff_c[31:2];
   assign unused_byte_off = diff_c[1:0];
   assign unused_seqaddr  = OPB_seqAddr;

   assign wr_en_c   = (state_q == S_ACK) && !rnw_q;
   assign be_mask_c = {{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}};

   always_comb begin
      rd_c = '0;
      for (int i = 0; i < C_NUM_REGS; i++) begin
         if (idx_c == 30'(i))
            rd_c = C_RO_MASK[i] ? user_data_in[i*32 +: 32] : regs_q[i];
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (hit_c) state_d = S_ACK;
         S_ACK:   state_d = S_DESEL;
         S_DESEL: if (!OPB_select) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // pulse registers fall back to zero on any cycle they are not written
   always_comb begin
      regs_d   = regs_q;
      strobe_d = '0;
      for (int i = 0; i < C_NUM_REGS; i++) begin
         if (wr_en_c && (idx_q == 30'(i)) && !C_RO_MASK[i]) begin
            regs_d[i]   = (regs_q[i] & ~be_mask_c) | (wdata_q & be_mask_c);
            strobe_d[i] = 1'b1;
         end else if (C_PULSE_MASK[i]) begin
            regs_d[i] = '0;
         end
      end
   end

   always_ff @(posedge OPB_Clk) begin
      if (OPB_Rst) begin
         state_q  <= S_IDLE;
         strobe_q <= '0;
         idx_q    <= '0;
         rnw_q    <= 1'b0;
         be_q     <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         for (int i = 0; i < C_NUM_REGS; i++) regs_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         strobe_q <= strobe_d;
         for (int i = 0; i < C_NUM_REGS; i++) regs_q[i] <= regs_d[i];
         if ((state_q == S_IDLE) && hit_c) begin
            idx_q   <= idx_c;
            rnw_q   <= OPB_RNW;
            be_q    <= OPB_BE;
            wdata_q <= OPB_DBus;
            rdata_q <= rd_c;
         end
      end
   end

   assign Sl_xferAck     = (state_q == S_ACK);
   assign Sl_DBus        = (Sl_xferAck && rnw_q) ? rdata_q : '0;
   assign Sl_errAck      = 1'b0;
   assign Sl_retry       = 1'b0;
   assign Sl_toutSup     = 1'b0;
   assign user_wr_strobe = strobe_q;

   for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_out
      assign user_data_out[g*32 +: 32] = regs_q[g];
   end

endmodule

// File: tb/tb_opb_register_bank.sv
// Directed bench for opb_register_bank: stimulus pushes expected acks/strobes,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_opb_register_bank;

   logic          clk = 1'b0;
   logic          rst;
   logic [0:31]   abus;
   logic [0:3]    be;
   logic [0:31]   dbus;
   logic          rnw;
   logic          sel;
   logic          seq_addr;
   logic [0:31]   sl_dbus;
   logic          sl_ack;
   logic          sl_err;
   logic          sl_retry;
   logic          sl_tout;
   logic [127:0]  udo;
   logic [3:0]    ustb;
   logic [127:0]  udi;

   typedef struct { int cyc; logic [31:0] data; } ack_t;
   typedef struct { int cyc; logic [3:0] strb; logic [127:0] udo; } stb_t;

   ack_t        ackq[$];
   stb_t        stbq[$];
   logic [31:0] mdl [4];
   int          cyc = 0;
   int          ack_count = 0;
   int          vectors = 0;
   int          miscompares = 0;
   logic        mon_en = 1'b0;

   opb_register_bank #(
      .C_NUM_REGS   (4),
      .C_PULSE_MASK (4'b0001),
      .C_RO_MASK    (4'b0100)
   ) dut (
      .OPB_Clk        (clk),
      .OPB_Rst        (rst),
      .OPB_ABus       (abus),
      .OPB_BE         (be),
      .OPB_DBus       (dbus),
      .OPB_RNW        (rnw),
      .OPB_select     (sel),
      .OPB_seqAddr    (seq_addr),
      .Sl_DBus        (sl_dbus),
      .Sl_xferAck     (sl_ack),
      .Sl_errAck      (sl_err),
      .Sl_retry       (sl_retry),
      .Sl_toutSup     (sl_tout),
      .user_data_out  (udo),
      .user_wr_strobe (ustb),
      .user_data_in   (udi)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [127:0] pack_mdl();
      return {mdl[3], mdl[2], mdl[1], mdl[0]};
   endfunction

   always @(negedge clk) begin
      if (mon_en) begin
         if (sl_ack) begin
            ack_count++;
            if (ackq.size() == 0) begin
               chk("unexpected_ack", 1, 0);
            end else begin
               ack_t e;
               e = ackq.pop_front();
               chk("ack_cycle", cyc, e.cyc);
               chk("ack_rdata", sl_dbus, e.data);
            end
         end else begin
            chk("dbus_idle_zero", sl_dbus, 0);
         end
         if (ustb != 4'b0000) begin
            if (stbq.size() == 0) begin
               chk("unexpected_strobe", ustb, 0);
            end else begin
               stb_t s;
               s = stbq.pop_front();
               chk("strobe_cycle", cyc, s.cyc);
               chk("strobe_bits", ustb, s.strb);
               chk("strobe_udo", udo, s.udo);
            end
         end
      end
   end

   // Call at #1 after a posedge with the FSM idle; returns likewise.
   // hold = number of cycles select stays high (>= 2); wr_reg < 0 means no strobe.
   task automatic xfer(input logic [31:0] addr, input logic r, input logic [3:0] b,
                       input logic [31:0] d, input int hold, input logic exp_ack,
                       input logic [31:0] exp_rd, input int wr_reg, input logic [31:0] new_val);
      int c, a0;
      abus = addr; rnw = r; be = b; dbus = d; sel = 1'b1;
      c  = cyc;
      a0 = ack_count;
      if (exp_ack) ackq.push_back('{c + 1, r ? exp_rd : 32'h0});
      if (wr_reg >= 0) begin
         mdl[wr_reg] = new_val;
         stbq.push_back('{c + 2, 4'(1 << wr_reg), pack_mdl()});
         if (wr_reg == 0) mdl[0] = 32'h0;
      end
      @(posedge clk); #1;
      abus = ~addr; dbus = ~d; be = ~b; rnw = ~r;
      repeat (hold - 1) begin @(posedge clk); #1; end
      sel = 1'b0;
      @(posedge clk); #1;
      if (!exp_ack) chk($sformatf("no_ack_%0h", addr), ack_count, a0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int a0, c;
      rst = 1'b1; sel = 1'b0; abus = '0; be = '0; dbus = '0; rnw = 1'b0;
      seq_addr = 1'b0; udi = '0;
      for (int i = 0; i < 4; i++) mdl[i] = 32'h0;
      repeat (3) @(posedge clk); #1;
      mon_en = 1'b1;
      chk("rst_ack", sl_ack, 0);
      chk("rst_dbus", sl_dbus, 0);
      chk("rst_udo", udo, 0);
      chk("rst_strobe", ustb, 0);
      chk("rst_tieoffs", {sl_err, sl_retry, sl_tout}, 0);

      // reset held during the hit cycle: transfer must be dropped
      abus = 32'h4; rnw = 1'b0; be = 4'hF; dbus = 32'h5555_5555; sel = 1'b1;
      a0 = ack_count;
      @(posedge clk); #1;
      rst = 1'b0; sel = 1'b0;
      repeat (3) @(posedge clk); #1;
      chk("rst_in_hit_no_ack", ack_count, a0);
      chk("rst_in_hit_reg1", udo[63:32], 0);

      xfer(32'h04, 0, 4'b1111, 32'hDEAD_BEEF, 2, 1, 0, 1, 32'hDEAD_BEEF);
      xfer(32'h04, 1, 4'b1111, 32'h0, 2, 1, 32'hDEAD_BEEF, -1, 0);
      chk("reg1_deadbeef", udo[63:32], 32'hDEAD_BEEF);

      xfer(32'h04, 0, 4'b1111, 32'h1122_3344, 2, 1, 0, 1, 32'h1122_3344);
      xfer(32'h04, 0, 4'b0101, 32'hAABB_CCDD, 2, 1, 0, 1, 32'h11BB_33DD);
      xfer(32'h04, 1, 4'b1111, 32'h0, 2, 1, 32'h11BB_33DD, -1, 0);

      xfer(32'h0C, 0, 4'b0000, 32'h1234_5678, 2, 1, 0, 3, 32'h0);
      xfer(32'h0C, 1, 4'b1111, 32'h0, 2, 1, 32'h0, -1, 0);

      xfer(32'h00, 0, 4'b1111, 32'h1, 2, 1, 0, 0, 32'h1);
      chk("pulse_cleared", udo[31:0], 0);
      xfer(32'h00, 1, 4'b1111, 32'h0, 2, 1, 32'h0, -1, 0);
      xfer(32'h00, 0, 4'b1111, 32'hA5, 2, 1, 0, 0, 32'hA5);
      xfer(32'h00, 0, 4'b1111, 32'h5A, 2, 1, 0, 0, 32'h5A);
      chk("pulse_cleared_b2b", udo[31:0], 0);

      udi[95:64] = 32'hCAFE_0001;
      xfer(32'h08, 1, 4'b1111, 32'h0, 2, 1, 32'hCAFE_0001, -1, 0);
      xfer(32'h08, 0, 4'b1111, 32'hFFFF_FFFF, 2, 1, 0, -1, 0);
      chk("ro_udo_zero", udo[95:64], 0);
      udi[95:64] = 32'h0BAD_F00D;
      xfer(32'h08, 1, 4'b1111, 32'h0, 2, 1, 32'h0BAD_F00D, -1, 0);

      xfer(32'h04, 1, 4'b1111, 32'h0, 7, 1, 32'h11BB_33DD, -1, 0);
      xfer(32'h20, 1, 4'b1111, 32'h0, 2, 1, 32'h0, -1, 0);
      xfer(32'h20, 0, 4'b1111, 32'hFFFF_FFFF, 2, 1, 0, -1, 0);
      xfer(32'h100, 1, 4'b1111, 32'h0, 2, 0, 0, -1, 0);
      xfer(32'h104, 0, 4'b1111, 32'hFFFF_FFFF, 2, 0, 0, -1, 0);
      chk("oob_write_no_change", udo, pack_mdl());

      // reset asserted during the ACK cycle of a write to reg 3
      abus = 32'h0C; rnw = 1'b0; be = 4'hF; dbus = 32'hFFFF_FFFF; sel = 1'b1;
      c = cyc;
      ackq.push_back('{c + 1, 32'h0});
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) mdl[i] = 32'h0;
      chk("rst_in_ack_udo", udo, 0);
      chk("rst_in_ack_strobe", ustb, 0);
      xfer(32'h0C, 0, 4'b1111, 32'h0000_00C3, 2, 1, 0, 3, 32'h0000_00C3);
      xfer(32'h0C, 1, 4'b1111, 32'h0, 2, 1, 32'h0000_00C3, -1, 0);
      chk("reg3_after_rst", udo[127:96], 32'h0000_00C3);

      repeat (3) @(posedge clk); #1;
      chk("ackq_drained", ackq.size(), 0);
      chk("stbq_drained", stbq.size(), 0);
      chk("end_tieoffs", {sl_err, sl_retry, sl_tout}, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
